// File: rtl/aes_pkg.sv
// Shared AES definitions: block size, byte/index types and the ShiftRows
// index maps used by the byte-serial datapath blocks.
package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;
    localparam int AES_IDX_W       = $clog2(AES_BLOCK_BYTES);

    typedef logic [7:0]           aes_byte_t;
    typedef logic [AES_IDX_W-1:0] aes_idx_t;

    // Byte index k = 4*col + row; the source column rotates left by the row number.
    function automatic aes_idx_t sr_idx(input aes_idx_t k);
        logic [1:0] row;
        logic [1:0] src_col;
        row     = k[1:0];
        src_col = k[3:2] + row;
        return {src_col, row};
    endfunction

    function automatic aes_idx_t inv_sr_idx(input aes_idx_t k);
        logic [1:0] row;
        logic [1:0] src_col;
        row     = k[1:0];
        src_col = k[3:2] - row;
        return {src_col, row};
    endfunction

endpackage

// File: rtl/sr_block_buf.sv
// One 16-byte AES state buffer: indexed write port, combinational read port
// and a full flag that marks the contents as a complete block.
module sr_block_buf
    import aes_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      wr_en,
    input  aes_idx_t  wr_idx,
    input  aes_byte_t wr_data,
    input  logic      set_full,
    input  logic      clr_full,
    input  aes_idx_t  rd_idx,
    output aes_byte_t rd_data,
    output logic      full
);

    aes_byte_t mem [AES_BLOCK_BYTES];

    // NOTE: the byte storage is deliberately not reset; the full flag alone
    // decides whether its contents are ever presented downstream.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
        end else if (set_full) begin
            full <= 1'b1;
        end else if (clr_full) begin
            full <= 1'b0;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/inv_shift_rows_stream.sv
// Byte-serial (Inv)ShiftRows over valid/ready streams with ping-pong buffers,
// sustaining one byte per cycle; INVERSE selects decryption or encryption order.
module inv_shift_rows_stream
    import aes_pkg::*;
#(
    parameter bit INVERSE = 1'b1
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       out_last
);

    localparam aes_idx_t LAST_IDX = aes_idx_t'(AES_BLOCK_BYTES - 1);

    logic      wr_sel;
    logic      rd_sel;
    aes_idx_t  wr_cnt;
    aes_idx_t  rd_cnt;
    aes_idx_t  rd_idx;
    logic [1:0] full;
    aes_byte_t rd_data [2];

    logic wr_fire;
    logic wr_done;
    logic rd_fire;
    logic rd_done;

    // Held low throughout reset even though both full flags are already clear.
    assign in_ready  = !rst && !full[wr_sel];
    assign out_valid = full[rd_sel];
    assign out_last  = out_valid && (rd_cnt == LAST_IDX);

    assign wr_fire = in_valid && in_ready;
    assign wr_done = wr_fire && (wr_cnt == LAST_IDX);
    assign rd_fire = out_valid && out_ready;
    assign rd_done = rd_fire && (rd_cnt == LAST_IDX);

    assign rd_idx = INVERSE ? inv_sr_idx(rd_cnt) : sr_idx(rd_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_sel <= 1'b0;
            wr_cnt <= '0;
        end else if (wr_fire) begin
            wr_cnt <= wr_cnt + 4'd1;
            if (wr_done) begin
                wr_sel <= !wr_sel;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_sel <= 1'b0;
            rd_cnt <= '0;
        end else if (rd_fire) begin
            rd_cnt <= rd_cnt + 4'd1;
            if (rd_done) begin
                rd_sel <= !rd_sel;
            end
        end
    end

    // A buffer is only ever completed while empty and drained while full,
    // so set and clear never target the same buffer in one cycle.
    for (genvar i = 0; i < 2; i++) begin : g_buf
        sr_block_buf u_buf (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_fire && (wr_sel == 1'(i))),
            .wr_idx   (wr_cnt),
            .wr_data  (in_byte),
            .set_full (wr_done && (wr_sel == 1'(i))),
            .clr_full (rd_done && (rd_sel == 1'(i))),
            .rd_idx   (rd_idx),
            .rd_data  (rd_data[i]),
            .full     (full[i])
        );
    end

    always_comb begin
        // NOTE: assign a default first so no branch leaves the output
        // unassigned, which would otherwise infer a latch.
        out_byte = '0;
        if (out_valid) begin
            out_byte = rd_data[rd_sel];
        end
    end

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Directed and scoreboarded bench for inv_shift_rows_stream, including a
// ShiftRows -> InvShiftRows round-trip chain.
module tb_inv_shift_rows_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       out_last;

    logic       rt_in_valid;
    logic       rt_in_ready;
    logic [7:0] rt_in_byte;
    logic       mid_valid;
    logic       mid_ready;
    logic [7:0] mid_byte;
    logic       mid_last;
    logic       rt_out_valid;
    logic       rt_out_ready;
    logic [7:0] rt_out_byte;
    logic       rt_out_last;

    inv_shift_rows_stream #(.INVERSE(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte), .out_last(out_last)
    );

    inv_shift_rows_stream #(.INVERSE(1'b0)) u_fwd (
        .clk(clk), .rst(rst),
        .in_valid(rt_in_valid), .in_ready(rt_in_ready), .in_byte(rt_in_byte),
        .out_valid(mid_valid), .out_ready(mid_ready), .out_byte(mid_byte), .out_last(mid_last)
    );

    inv_shift_rows_stream #(.INVERSE(1'b1)) u_inv (
        .clk(clk), .rst(rst),
        .in_valid(mid_valid), .in_ready(mid_ready), .in_byte(mid_byte),
        .out_valid(rt_out_valid), .out_ready(rt_out_ready), .out_byte(rt_out_byte), .out_last(rt_out_last)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ready_mode = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model_idx(input int k, input bit inv);
        int row;
        int col;
        int src_col;
        row = k % 4;
        col = k / 4;
        src_col = inv ? (col - row + 4) % 4 : (col + row) % 4;
        return src_col * 4 + row;
    endfunction

    // Main DUT scoreboard: every output byte is checked against the accepted input.
    logic [7:0] in_q[$];
    logic [7:0] out_log[$];
    logic       last_log[$];
    int         out_cyc[$];
    int         out_n = 0;
    int         last_in_cyc = 0;
    int         sb_blk;
    int         sb_k;
    int         sb_src;

    always @(negedge clk) begin
        if (rst) begin
            in_q.delete();
            out_log.delete();
            last_log.delete();
            out_cyc.delete();
            out_n = 0;
        end else begin
            if (out_valid && out_ready) begin
                sb_blk = out_n / 16;
                sb_k   = out_n % 16;
                sb_src = sb_blk * 16 + model_idx(sb_k, 1'b1);
                check("sb_block_complete", in_q.size() >= sb_blk * 16 + 16, 1);
                if (in_q.size() > sb_src) check("sb_byte", out_byte, in_q[sb_src]);
                check("sb_last", out_last, sb_k == 15);
                out_log.push_back(out_byte);
                last_log.push_back(out_last);
                out_cyc.push_back(cyc);
                out_n++;
            end
            if (in_valid && in_ready) begin
                in_q.push_back(in_byte);
                last_in_cyc = cyc;
            end
        end
    end

    logic [7:0] fwd_log[$];
    logic [7:0] rt_log[$];
    int         rt_cyc[$];

    always @(negedge clk) begin
        if (rst) begin
            fwd_log.delete();
            rt_log.delete();
            rt_cyc.delete();
        end else begin
            if (mid_valid && mid_ready) fwd_log.push_back(mid_byte);
            if (rt_out_valid && rt_out_ready) begin
                rt_log.push_back(rt_out_byte);
                rt_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(1));
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the last byte is accepted.
    task automatic send_bytes(input logic [7:0] b [16], input int n, input int idle_pct, input bit chain);
        bit fired;
        int budget;
        for (int i = 0; i < n; i++) begin
            while (idle_pct > 0 && $urandom_range(99) < idle_pct) begin
                in_valid = 1'b0;
                step();
            end
            if (chain) begin
                rt_in_valid = 1'b1;
                rt_in_byte  = b[i];
            end else begin
                in_valid = 1'b1;
                in_byte  = b[i];
            end
            budget = 0;
            do begin
                @(negedge clk);
                fired = chain ? rt_in_ready : in_ready;
                step();
                budget++;
            end while (!fired && budget < 500);
            if (!fired) check("in_accept_timeout", fired, 1);
        end
        in_valid    = 1'b0;
        rt_in_valid = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int budget;
        budget = 0;
        while (out_n < n && budget < 3000) begin
            @(posedge clk);
            budget++;
        end
        #1;
        check("drain_count", out_n, n);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_byte"}, out_byte, 8'h00);
        check({tag, "_out_last"}, out_last, 0);
    endtask

    logic [7:0] exp_inv [16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                                 8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
    logic [7:0] exp_fwd [16] = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                                 8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};

    logic [7:0] blk [16];
    logic [7:0] blk2 [16];
    logic [7:0] rt_sent[$];
    logic [7:0] held;
    int         gaps;
    int         budget;

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_byte     = 8'h00;
        rt_in_valid = 1'b0;
        rt_in_byte  = 8'h00;
        rt_out_ready = 1'b1;

        // Reset state and first-cycle readiness.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        step();
        rst = 1'b0;
        #1;
        check("in_ready_after_reset", in_ready, 1);

        // InvShiftRows of 00..0F, back-to-back with out_ready high.
        for (int i = 0; i < 16; i++) blk[i] = 8'(i);
        send_bytes(blk, 16, 0, 1'b0);
        wait_out(16);
        for (int i = 0; i < 16; i++) begin
            check("inv_vector_byte", out_log[i], exp_inv[i]);
            check("inv_vector_last", last_log[i], i == 15);
        end
        check("first_out_latency", out_cyc[0], last_in_cyc + 1);

        // ShiftRows chained into InvShiftRows: forward vector, then identity round trip.
        send_bytes(blk, 16, 0, 1'b1);
        for (int i = 0; i < 16; i++) rt_sent.push_back(blk[i]);
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 16; i++) begin
                blk2[i] = 8'($urandom_range(255));
                rt_sent.push_back(blk2[i]);
            end
            send_bytes(blk2, 16, 0, 1'b1);
        end
        budget = 0;
        while (rt_log.size() < 64 && budget < 500) begin
            step();
            budget++;
        end
        check("rt_count", rt_log.size(), 64);
        for (int i = 0; i < 16; i++) check("fwd_vector_byte", fwd_log[i], exp_fwd[i]);
        gaps = 0;
        for (int i = 0; i < rt_log.size(); i++) begin
            check("rt_byte", rt_log[i], rt_sent[i]);
            if (i > 0 && rt_cyc[i] != rt_cyc[i-1] + 1) gaps++;
        end
        check("rt_bubbles", gaps, 0);

        // Downstream stalled across two blocks, then released.
        ready_mode = 1;
        step();
        for (int i = 0; i < 16; i++) begin
            blk[i]  = 8'($urandom_range(255));
            blk2[i] = 8'($urandom_range(255));
        end
        send_bytes(blk, 16, 0, 1'b0);
        send_bytes(blk2, 16, 0, 1'b0);
        check("stall_in_ready_low", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        held = out_byte;
        check("stall_first_byte", held, blk[model_idx(0, 1'b1)]);
        repeat (3) step();
        check("stall_hold_byte", out_byte, held);
        check("stall_no_output", out_n, 16);
        ready_mode = 0;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!(out_valid && out_ready && out_last) && budget < 200);
        check("free_same_cycle", in_ready, 0);
        @(negedge clk);
        check("free_next_cycle", in_ready, 1);
        step();
        wait_out(48);

        // Random throttling on both streams over 50 blocks.
        ready_mode = 2;
        for (int b = 0; b < 50; b++) begin
            for (int i = 0; i < 16; i++) blk[i] = 8'($urandom_range(255));
            send_bytes(blk, 16, 30, 1'b0);
        end
        ready_mode = 0;
        wait_out(848);
        check("random_no_loss", out_n, in_q.size());

        // Reset after a partial block.
        for (int i = 0; i < 16; i++) blk[i] = 8'($urandom_range(255));
        send_bytes(blk, 7, 0, 1'b0);
        check("partial_no_output", out_valid, 0);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_partial");
        repeat (2) step();
        check_reset_outputs("rst_partial_held");
        rst = 1'b0;
        for (int i = 0; i < 16; i++) blk[i] = 8'(8'hA0 + i);
        send_bytes(blk, 16, 0, 1'b0);
        wait_out(16);

        // Reset in the middle of draining a block.
        ready_mode = 1;
        step();
        for (int i = 0; i < 16; i++) blk[i] = 8'($urandom_range(255));
        send_bytes(blk, 16, 0, 1'b0);
        ready_mode = 0;
        wait_out(21);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_drain");
        repeat (2) step();
        rst = 1'b0;
        repeat (5) step();
        check("post_reset_idle", out_valid, 0);
        for (int i = 0; i < 16; i++) blk[i] = 8'(8'h5A ^ (i * 7));
        send_bytes(blk, 16, 0, 1'b0);
        wait_out(16);
        repeat (20) step();
        check("post_reset_no_stale", out_n, 16);
        check("post_reset_in_count", in_q.size(), 16);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
